// File: rtl/vga_timing_pkg.sv
// Shared timing types and defaults for the VGA raster generator.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel rate.
package vga_timing_pkg;

  // Horizontal defaults (pixels)
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  // Vertical defaults (lines)
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Both syncs are active-low in the classic 640x480 mode
  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b0;

  // Wide enough for 800 pixels and 525 lines
  localparam int unsigned VGA_CW = 11;

  // One axis of raster timing. Segment order along the axis is
  // active, front porch, sync, back porch.
  typedef struct packed {
    int unsigned len_active;
    int unsigned len_fp;
    int unsigned len_sync;
    int unsigned len_bp;
    logic        pol;
  } axis_timing_t;

  // Positions per axis period (pixels per line or lines per frame)
  function automatic int unsigned axis_total(input axis_timing_t t);
    return t.len_active + t.len_fp + t.len_sync + t.len_bp;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter with wrap, sync/active decode of
// the next position, and a one-clock strobe when position returns to 0.
// Chained twice (pixels, then lines) to form the full raster.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = VGA_H_POL,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active_next,
  output logic          wrap,
  output logic          start
);

  localparam axis_timing_t TIMING = '{
    len_active: ACTIVE,
    len_fp:     FP,
    len_sync:   SYNC,
    len_bp:     BP,
    pol:        POL
  };
  localparam int unsigned TOTAL = axis_total(TIMING);

  // Segment boundaries expressed in counter width
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEGIN = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  // Elaboration-time sanity: every segment present, counter wide enough
  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_segment
    $error("vga_axis_timer: every timing segment must be nonzero");
  end
  if (CW == 0 || CW > 31 || TOTAL > (32'd1 << CW)) begin : g_bad_width
    $error("vga_axis_timer: CW too narrow for axis total");
  end

  logic [CW-1:0] count_next;
  logic          at_last;
  logic          in_sync_next;

  assign at_last = (count == LAST);

  // Carry into the next axis: this axis is leaving its last position
  assign wrap = advance && at_last;

  // Next position: step when advanced, wrapping from the last position
  always_comb begin
    count_next = count;
    if (advance) begin
      count_next = at_last ? '0 : count + 1'b1;
    end
  end

  // Decodes are taken on the next position so the registered flags line
  // up with the registered count in the same cycle
  assign active_next  = (count_next < ACTIVE_END);
  assign in_sync_next = (count_next >= SYNC_BEGIN) && (count_next < SYNC_END);

  // Position, sync level and return-to-zero strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST;
      sync  <= !POL;
      start <= 1'b0;
    end else begin
      count <= count_next;
      sync  <= in_sync_next ? POL : !POL;
      // Entering position 0 happens exactly on a wrap, so the strobe
      // lasts one clock regardless of how long advance stays high
      start <= wrap;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis timers
// chained through the horizontal wrap, plus the display-enable flag.
// Reset parks the raster on the last back-porch position so the first
// pixel enable lands on (0,0) and starts a complete frame.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          H_POL    = VGA_H_POL,
  parameter bit          V_POL    = VGA_V_POL,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap;
  logic h_active_next;
  logic v_active_next;
  logic v_wrap_unused;  // end-of-frame carry; nothing downstream chains off it

  // Pixel axis: steps on every enabled pixel clock
  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (pix_en),
    .count       (h_count),
    .sync        (h_sync),
    .active_next (h_active_next),
    .wrap        (h_wrap),
    .start       (line_start)
  );

  // Line axis: steps only when the pixel axis wraps, so v_sync can only
  // change in the cycle where h_count becomes 0
  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (h_wrap),
    .count       (v_count),
    .sync        (v_sync),
    .active_next (v_active_next),
    .wrap        (v_wrap_unused),
    .start       (frame_start)
  );

  // Display enable registered from both next-position decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de <= 1'b0;
    end else begin
      de <= h_active_next && v_active_next;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Replaces the horizontal-only sync counter with a combined horizontal/vertical generator. Adds configurable porches, sync widths and sync polarity, a pixel clock-enable, a display-enable output, and line/frame start strobes. Feeds the pixel pipeline and the VGA output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, h_sync active level (0 = active-low, 1 = active-high)
V_POL, 0, v_sync active level
CW, 11, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel advance enable; tie high for one pixel per clk
h_count  out  CW  current horizontal position
v_count  out  CW  current vertical position
h_sync  out  1  horizontal sync, polarity set by H_POL
v_sync  out  1  vertical sync, polarity set by V_POL
de  out  1  display enable; high in the active region
line_start  out  1  one-clk pulse when h_count becomes 0
frame_start  out  1  one-clk pulse when (h_count, v_count) becomes (0, 0)

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line order: active, front porch, sync, back porch. Counter 0 is the first visible pixel/line.
- Reset values:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1 (last back-porch position).
  - de = 0; h_sync = !H_POL; v_sync = !V_POL; line_start = 0; frame_start = 0.
  - The first pix_en after reset moves to (0,0) and raises line_start and frame_start, so frame 0 is complete.
- On a clk edge with pix_en = 1:
  - h_count = (h_count == H_TOTAL-1) ? 0 : h_count+1.
  - v_count advances only when h_count wraps: (v_count == V_TOTAL-1) ? 0 : v_count+1.
- pix_en = 0: counters, de and both syncs hold; line_start and frame_start are 0.
- Decode alignment: h_sync, v_sync and de are registered decodes of the next counter values. They are therefore aligned with h_count/v_count in the same cycle, with zero offset between position and flags.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - h_sync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - v_sync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491); it toggles only in cycles where h_count becomes 0.
- Strobes:
  - High for exactly one clk, in the cycle after the pix_en edge that entered the position.
  - Never high for more than one clk, even if pix_en stays high.
  - frame_start implies line_start.
- Reset mid-frame: all outputs return to reset values immediately (async). Counting resumes from the reset position on the first pix_en after rst_n deasserts.
- No other inputs. Parameter sanity (nonzero widths, CW fits) is checked by elaboration-time assertions.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for the 640x480@60 default;
  - a timing-parameter struct (active, fp, sync, bp, pol);
  - a function computing total from the struct.
- Sub-module vga_axis_timer holds one axis: counter, wrap, sync/active decode and strobe. It has an advance input and a wrap output.
- vga_timing_gen instantiates vga_axis_timer twice. The horizontal wrap drives the vertical advance.

Test Plan:
- Reset then pix_en = 1 for one clk -> h_count = 0, v_count = 0, de = 1, line_start = 1, frame_start = 1; next clk both strobes 0.
- Defaults, run one line -> h_sync low exactly for h_count 656..751 (96 clks); de high for h_count 0..639; line period 800 clks.
- Run full frame -> v_sync low for v_count 490..491 (1600 clks), changing only where h_count = 0; frame_start period 420000 clks; de never high for v_count >= 480.
- pix_en toggled 1/0 each clk -> counters advance every other clk; line period 1600 clks; strobes stay single-clk; syncs and de hold during pix_en = 0.
- Instance with H_POL = 1, V_POL = 1, small timing (H 8/2/2/2, V 4/1/1/1) -> h_sync high for h 10..11; v_sync high for v 5; totals 14 x 7.
- Assert rst_n low at h_count = 300, v_count = 100 -> outputs reach reset values without a clk edge; after release, the first pix_en gives (0,0) plus frame_start.
